// File: rtl/vend_input_conditioner.sv
// Vending machine input front end: per-channel synchronize, debounce and
// rising-edge capture, then a fixed-priority arbiter that emits at most one
// registered event pulse per clock toward the vending FSM.

// One input channel: 2-flop synchronizer, debouncer, rise detect, pending bit.
module vend_ic_chan #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic grant,
  output logic pending,
  output logic drop
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Counter value seen on the edge where the N-th mismatching cycle completes.
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2, stable, stable_d;
  logic [CW-1:0] cnt;
  logic          rise;

  assign rise = stable & ~stable_d;
  // A rise while an un-granted event is still queued cannot be represented.
  assign drop = rise & pending & ~grant;

  // Synchronize, then accept a new level only after N consecutive mismatches.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      stable_d <= stable;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Queue one event per debounced rise; the arbiter grant retires it.
  always_ff @(posedge clk) begin
    if (reset) pending <= 1'b0;
    else       pending <= (pending & ~grant) | rise;
  end
endmodule

module vend_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       quarter_raw,
  input  logic       dime_raw,
  input  logic       nickel_raw,
  input  logic       soda_raw,
  input  logic       diet_raw,
  output logic       quarter,
  output logic       dime,
  output logic       nickel,
  output logic       soda,
  output logic       diet,
  output logic [7:0] accept_count,
  output logic       dropped
);
  localparam int NUM_CH = 5;

  // Bit 0 is the highest priority: quarter, dime, nickel, soda, diet.
  logic [NUM_CH-1:0] raw, pending, grant, drop, ev;

  assign raw = {diet_raw, soda_raw, nickel_raw, dime_raw, quarter_raw};

  vend_ic_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan [NUM_CH-1:0] (
    .clk    (clk),
    .reset  (reset),
    .raw    (raw),
    .grant  (grant),
    .pending(pending),
    .drop   (drop)
  );

  // Isolate the lowest set pending bit: highest-priority waiting event.
  assign grant = pending & (~pending + NUM_CH'(1));

  // Register the winning event, count emitted pulses, latch any loss.
  always_ff @(posedge clk) begin
    if (reset) begin
      ev           <= '0;
      accept_count <= '0;
      dropped      <= 1'b0;
    end else begin
      ev <= grant;
      if ((|grant) && (accept_count != 8'hFF)) accept_count <= accept_count + 8'd1;
      if (|drop) dropped <= 1'b1;
    end
  end

  assign {diet, soda, nickel, dime, quarter} = ev;
endmodule

// File: tb/tb_vend_input_conditioner.sv
// Directed bench for vend_input_conditioner: a vector table of single
// press patterns plus hand sequences for reset, ordering, overflow and
// count saturation. Main instance uses N=3; a second instance with N=1
// lets the bench starve a channel long enough to force an overflow.
module tb_vend_input_conditioner;
  localparam int N   = 3;
  localparam int LAT = N + 3;  // iterations from raw rise to visible pulse

  localparam logic [4:0] Q  = 5'b00001;
  localparam logic [4:0] D  = 5'b00010;
  localparam logic [4:0] NK = 5'b00100;
  localparam logic [4:0] S  = 5'b01000;
  localparam logic [4:0] DT = 5'b10000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] raw = '0, raw1 = '0;
  logic       q, d, n, s, dt;
  logic       q1, d1, n1, s1, dt1;
  logic [7:0] cnt, cnt1;
  logic       drp, drp1;

  int total = 0;
  int passed = 0;

  vend_input_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .reset(reset),
    .quarter_raw(raw[0]), .dime_raw(raw[1]), .nickel_raw(raw[2]),
    .soda_raw(raw[3]), .diet_raw(raw[4]),
    .quarter(q), .dime(d), .nickel(n), .soda(s), .diet(dt),
    .accept_count(cnt), .dropped(drp)
  );

  vend_input_conditioner #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset),
    .quarter_raw(raw1[0]), .dime_raw(raw1[1]), .nickel_raw(raw1[2]),
    .soda_raw(raw1[3]), .diet_raw(raw1[4]),
    .quarter(q1), .dime(d1), .nickel(n1), .soda(s1), .diet(dt1),
    .accept_count(cnt1), .dropped(drp1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      raw;
    int              hold;
    int              npulse;
    logic [4:0][4:0] seq;   // seq[i] is the i-th expected pulse
  } vec_t;

  localparam int NV = 8;
  vec_t tbl [NV];

  logic [4:0] seq_ev [5];
  int         seq_t  [5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] ev_now();
    return {dt, s, n, d, q};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    raw   = '0;
    raw1  = '0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  initial begin
    int np, multi, c0, pt, pulses, mism;
    logic [4:0] e;

    tbl[0] = '{raw: Q,          hold: 6,  npulse: 1, seq: {5'd0, 5'd0, 5'd0, 5'd0, Q}};
    tbl[1] = '{raw: NK,         hold: 6,  npulse: 1, seq: {5'd0, 5'd0, 5'd0, 5'd0, NK}};
    tbl[2] = '{raw: DT,         hold: 2,  npulse: 0, seq: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0}};
    tbl[3] = '{raw: DT,         hold: 3,  npulse: 1, seq: {5'd0, 5'd0, 5'd0, 5'd0, DT}};
    tbl[4] = '{raw: Q | D | S,  hold: 6,  npulse: 3, seq: {5'd0, 5'd0, S, D, Q}};
    tbl[5] = '{raw: D,          hold: 1,  npulse: 0, seq: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0}};
    tbl[6] = '{raw: S,          hold: 12, npulse: 1, seq: {5'd0, 5'd0, 5'd0, 5'd0, S}};
    tbl[7] = '{raw: 5'h1F,      hold: 6,  npulse: 5, seq: {DT, S, NK, D, Q}};

    seq_ev = '{NK, D, Q, NK, S};
    seq_t  = '{0 + LAT, 12 + LAT, 24 + LAT, 36 + LAT, 48 + LAT};

    // Reset with every raw input held high.
    reset = 1'b1;
    raw   = 5'h1F;
    repeat (3) step();
    chk("reset events", int'(ev_now()), 0);
    chk("reset count", int'(cnt), 0);
    chk("reset dropped", int'(drp), 0);
    chk("reset dropped n1", int'(drp1), 0);
    reset = 1'b0;
    np = 0; pt = -1; multi = 0;
    for (int t = 0; t < 14; t++) begin
      step();
      if ($countones(ev_now()) > 1) multi++;
      if (q) begin np++; pt = t; end
    end
    chk("post-reset quarter pulses", np, 1);
    chk("post-reset quarter step", pt, LAT);
    chk("post-reset one-hot", multi, 0);
    chk("post-reset count", int'(cnt), 5);
    raw = '0;
    repeat (16) step();

    // Ordered sequence of presses with fixed latency.
    do_reset();
    np = 0;
    for (int t = 0; t < 70; t++) begin
      raw = '0;
      if (t < 6 || (t >= 36 && t < 42)) raw[2] = 1'b1;
      if (t >= 12 && t < 18) raw[1] = 1'b1;
      if (t >= 24 && t < 30) raw[0] = 1'b1;
      if (t >= 48 && t < 54) raw[3] = 1'b1;
      step();
      e = ev_now();
      if (e != '0) begin
        if (np < 5) begin
          chk($sformatf("seq pulse%0d chan", np), int'(e), int'(seq_ev[np]));
          chk($sformatf("seq pulse%0d step", np), t, seq_t[np]);
        end
        np++;
      end
    end
    chk("seq pulses", np, 5);
    chk("seq count", int'(cnt), 5);
    chk("seq dropped", int'(drp), 0);

    // Vector table: one press pattern per record.
    for (int r = 0; r < NV; r++) begin
      c0 = int'(cnt); np = 0; multi = 0;
      for (int t = 0; t < 26; t++) begin
        raw = (t < tbl[r].hold) ? tbl[r].raw : 5'b0;
        step();
        e = ev_now();
        if ($countones(e) > 1) multi++;
        if (e != '0) begin
          if (np < 5) begin
            chk($sformatf("vec%0d pulse%0d chan", r, np), int'(e), int'(tbl[r].seq[np]));
            chk($sformatf("vec%0d pulse%0d step", r, np), t, LAT + np);
          end
          np++;
        end
      end
      chk($sformatf("vec%0d pulses", r), np, tbl[r].npulse);
      chk($sformatf("vec%0d one-hot", r), multi, 0);
      chk($sformatf("vec%0d count delta", r), int'(cnt) - c0, tbl[r].npulse);
    end

    // Reset while a press is in flight; the still-high input re-triggers.
    do_reset();
    raw = Q;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    np = 0; pt = -1;
    for (int t = 0; t < 14; t++) begin
      step();
      if (q) begin np++; pt = t; end
    end
    chk("mid-reset quarter pulses", np, 1);
    chk("mid-reset quarter step", pt, LAT);
    chk("mid-reset count", int'(cnt), 1);
    raw = '0;
    repeat (12) step();

    // Overflow on the N=1 instance: quarter and dime alternate so nickel
    // never wins and its next rise finds the pending bit still set.
    do_reset();
    chk("ovf dropped before", int'(drp1), 0);
    multi = 0;
    for (int t = 0; t < 20; t++) begin
      raw1 = t[0] ? (Q | NK) : D;
      step();
      if ($countones({dt1, s1, n1, d1, q1}) > 1) multi++;
    end
    raw1 = '0;
    repeat (10) step();
    chk("ovf dropped set", int'(drp1), 1);
    chk("ovf one-hot", multi, 0);
    repeat (10) step();
    chk("ovf dropped sticky", int'(drp1), 1);
    do_reset();
    chk("ovf dropped cleared", int'(drp1), 0);

    // Saturation: all channels toggling, 260+ pulses.
    do_reset();
    pulses = 0; mism = 0; c0 = 0;
    for (int t = 0; t < 1500 && pulses < 262; t++) begin
      raw = ((t % 8) < 4) ? 5'h1F : 5'h00;
      step();
      if (ev_now() != '0) begin
        pulses++;
        if (pulses > 255) c0++;
      end
      if (int'(cnt) != ((pulses > 255) ? 255 : pulses)) mism++;
    end
    chk("sat pulses emitted", (pulses >= 260) ? 1 : 0, 1);
    chk("sat pulses past 255", (c0 >= 5) ? 1 : 0, 1);
    chk("sat count", int'(cnt), 255);
    chk("sat count tracking", mism, 0);
    chk("sat dropped", int'(drp), 0);
    raw = '0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vend_input_conditioner.md
# vend_input_conditioner

Input front end for the vending machine FSM (`VendingMealy`). It takes raw, asynchronous coin-mechanism and button levels, synchronizes and debounces each one, and turns each press or insertion into exactly one single-cycle event pulse. It arbitrates so that at most one event reaches the FSM per clock. Its outputs connect directly to the `quarter`, `dime`, `nickel`, `soda` and `diet` inputs of `VendingMealy`, on the same clock and reset.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized cycles required before a level change is accepted. Legal range 1..255.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `quarter_raw`, `dime_raw`, `nickel_raw` in 1 each: raw coin-sensor levels, asynchronous, active-high.
- `soda_raw`, `diet_raw` in 1 each: raw selection-button levels, asynchronous, active-high.
- `quarter`, `dime`, `nickel`, `soda`, `diet` out 1 each: registered one-cycle event pulses. At most one is high in any cycle.
- `accept_count` out 8: number of events emitted since reset; saturates at 255.
- `dropped` out 1: sticky flag, set when an event is lost to overflow.

## Operation
Each of the 5 channels has its own pipeline:
- **Synchronizer:** 2-flop chain, `s1` then `s2`.
- **Debouncer:**
  - Holds a `stable` level register and a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `s2 == stable`, the counter clears to 0.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES`, on that edge `stable <= s2` and the counter clears.
- **Edge detect:** a 0->1 transition of `stable` sets the channel's `pending` bit on the next edge. A 1->0 transition produces nothing.
- **Arbiter:**
  - Each cycle, the highest-priority set `pending` bit is emitted: its output is registered high for one cycle and that `pending` bit clears on the same edge.
  - Priority order: quarter > dime > nickel > soda > diet.
  - Lower-priority pending bits wait; they are never discarded.
- **Overflow:** if a new rising edge on `stable` occurs while that channel's `pending` bit is still set, the new event is discarded. `pending` stays 1 and `dropped <= 1`.
- **Counting:** `accept_count` increments on every emitted pulse and holds at 255.
- **Held input:** a raw input held high indefinitely yields exactly one pulse. Release, debounced, plus a re-press yields a second pulse.
- **Glitch rejection:** a glitch shorter than `DEBOUNCE_CYCLES` cycles after synchronization yields no pulse and no state change in `stable`.

## Timing
- **Reset:** while `reset` is sampled high, the following clear to 0 on that edge:
  - all `s1`, `s2`, `stable`, counters and `pending` bits;
  - all five event outputs;
  - `accept_count` and `dropped`.
- **Reset mid-operation:** pulses in flight or pending are discarded. A raw input still high after reset release counts as a fresh press and produces one pulse after the full latency.
- **Latency:**
  - Let edge k be the first edge that samples a raw input high; `s1` is set at k, `s2` at k+1.
  - Counter reaches `DEBOUNCE_CYCLES` and `stable` sets at edge k+1+N, where N = `DEBOUNCE_CYCLES`.
  - `pending` sets at k+2+N.
  - Uncontended, the output is high from edge k+3+N to edge k+4+N.
- **Contention:** each higher-priority pending event ahead of a channel adds one cycle to its latency.
- **Throughput:** one event per cycle maximum. There are no back-to-back duplicates from a single press.
- **Outputs:** all outputs are registered. There are no combinational paths from raw inputs to outputs.

## Test plan
- **Reset:** drive all raw inputs 1 with `reset=1` for 3 cycles. Required: all outputs 0, `accept_count=0`, `dropped=0`. Then release reset: exactly one `quarter` pulse occurs at edge N+3 after release (with N=3, edge 6).
- **Sequence and latency:** with N=3, insert nickel, dime, quarter, nickel, each held 6 cycles and separated by 6 cycles low, then press soda.
  - Required: 5 single-cycle pulses in that order, each 6 cycles after its raw rise.
  - Required: `accept_count=5`, `dropped=0`.
- **Glitch rejection:** with N=3, hold `diet_raw` high for 2 cycles, then low. Required: no `diet` pulse and `accept_count` unchanged. Then hold it 3 cycles: exactly one pulse.
- **Simultaneous events:** raise `quarter_raw`, `dime_raw` and `soda_raw` on the same edge. Required: `quarter` at latency L, `dime` at L+1, `soda` at L+2, never two outputs high together.
- **Overflow:** hold `nickel_raw` and `quarter_raw` high, then toggle `nickel_raw` fast enough (above N cycles per level) while `quarter` continuously wins arbitration via repeated quarter presses. Required: `dropped` goes 1 and stays 1 until reset.
- **Saturation:** emit 260 pulses. Required: `accept_count` stops at 255 and pulses continue to be emitted.
